// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory read port, redirect input from
// execute, and the valid/ready instruction stream to decode.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    modport master (
        output imem_addr, imem_rd_en, out_valid, out_instr, out_pc, misalign_err,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, imem_rd_en, out_valid, out_instr, out_pc, misalign_err,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, zero-wait-state imem issue, skid FIFO of
// {pc, instr} toward decode, and flush-on-redirect from execute.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]                  fetch_pc;
    logic [FIFO_DEPTH-1:0][31:0]  fifo_instr;
    logic [FIFO_DEPTH-1:0][31:0]  fifo_pc;
    logic [PW-1:0]                rd_ptr;
    logic [PW-1:0]                wr_ptr;
    logic [CW-1:0]                count;
    logic                         misalign_q;

    logic pop;
    logic issue;

    // Redirect wins over everything: no pop and no issue in that cycle.
    assign pop   = bus.out_valid & bus.out_ready & ~bus.redirect_valid;
    assign issue = ~rst & ~bus.redirect_valid & ((count < CW'(FIFO_DEPTH)) | pop);

    assign bus.imem_rd_en   = issue;
    assign bus.imem_addr    = {{(32-ADDR_W){1'b0}}, fetch_pc[ADDR_W+1:2]};
    assign bus.out_valid    = (count != '0);
    assign bus.out_instr    = fifo_instr[rd_ptr];
    assign bus.out_pc       = fifo_pc[rd_ptr];
    assign bus.misalign_err = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            fifo_instr <= '0;
            fifo_pc    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc   <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            misalign_q <= (bus.redirect_pc[1:0] != 2'b00);
        end else begin
            misalign_q <= 1'b0;
            // Memory returned the word at this edge, so capture it alongside its PC.
            if (issue) begin
                fifo_instr[wr_ptr] <= bus.imem_instr;
                fifo_pc[wr_ptr]    <= fetch_pc;
                wr_ptr             <= wr_ptr + PW'(1);
                fetch_pc           <= fetch_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({issue, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
